// File: rtl/trap_scheduler_pkg.sv
// Shared definitions for the trap scheduler.
//   - machine interrupt cause codes (MSI/MTI/MEI)
//   - mstatus.MIE bit position and the U-mode privilege encoding
//   - 2-bit scheduler FSM state type (exposed on the state_dbg port)
//   - irq_cause(): builds an interrupt mcause value from a 5-bit code
package trap_scheduler_pkg;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  localparam int MSTATUS_MIE = 3;

  localparam logic [1:0] PRIVILEGE_MODE_U = 2'b00;

  typedef enum logic [1:0] {
    TS_RUN   = 2'd0,
    TS_SLEEP = 2'd1,
    TS_REQ   = 2'd2,
    TS_WAIT  = 2'd3
  } ts_state_e;

  // Interrupt causes carry bit 31 set and the code in the low bits.
  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

endpackage

// File: rtl/trap_scheduler_if.sv
// Trap request channel between the trap scheduler (master) and the
// CSR unit / main control FSM (slave).
//   trap_event   : one-cycle request; trap_cause/trap_pc/trap_badaddr are
//                  valid while it is high and stay stable until the next trap.
//   redirect_ack : completion; the main FSM has loaded the trap vector PC.
// Handshake: trap_event is a single-cycle pulse and does not wait for a
// ready. The scheduler then holds the core until redirect_ack is seen; an
// ack is only accepted after the trap_event cycle, an ack during the pulse
// itself is ignored.
interface trap_scheduler_if;
  logic        trap_event;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_badaddr;
  logic        redirect_ack;

  modport master (
    output trap_event, trap_cause, trap_pc, trap_badaddr,
    input  redirect_ack
  );

  modport slave (
    input  trap_event, trap_cause, trap_pc, trap_badaddr,
    output redirect_ack
  );
endinterface

// File: rtl/trap_scheduler_irq_sync.sv
// N-stage flip-flop synchroniser for one asynchronous IRQ pin.
//   clk    : destination clock
//   resetn : asynchronous active-low reset, clears every stage
//   d      : raw asynchronous input
//   q      : synchronised output (last stage), N cycles after d
module trap_scheduler_irq_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ff <= '0;
    else         ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/trap_scheduler.sv
// Trap entry sequencer for the rv32ima multicycle core.
// Synchronises the raw IRQ pins, arbitrates synchronous exceptions against
// pending interrupts at instruction boundaries, handles WFI sleep/wake and
// issues a one-cycle trap request, holding the core until the PC redirect
// is acknowledged.
// Ports:
//   clk, resetn                          clock, async active-low reset
//   irq_sw/tmr/ext_raw                   asynchronous IRQ pins
//   irq_msip, irq_mtip                   synchronised SW/timer IRQ to the CSR unit
//   mip, mie, mstatus, privilege_mode    CSR state used for interrupt arbitration
//   boundary, next_pc                    fetch boundary and PC of next instruction
//   exc_valid/cause/pc/badaddr           synchronous exception report
//   wfi                                  WFI retired pulse
//   trap_bus (master)                    trap_event/trap_* out, redirect_ack in
//   hold, sleeping, ack_fault            stall, WFI sleep, sticky ack timeout
//   state_dbg                            current FSM state
module trap_scheduler
  import trap_scheduler_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    irq_sw_raw,
  input  logic                    irq_tmr_raw,
  input  logic                    irq_ext_raw,
  output logic                    irq_msip,
  output logic                    irq_mtip,
  input  logic [31:0]             mip,
  input  logic [31:0]             mie,
  input  logic [31:0]             mstatus,
  input  logic [1:0]              privilege_mode,
  input  logic                    boundary,
  input  logic [31:0]             next_pc,
  input  logic                    exc_valid,
  input  logic [31:0]             exc_cause,
  input  logic [31:0]             exc_pc,
  input  logic [31:0]             exc_badaddr,
  input  logic                    wfi,
  trap_scheduler_if.master        trap_bus,
  output logic                    hold,
  output logic                    sleeping,
  output logic                    ack_fault,
  output ts_state_e               state_dbg
);

  // Last T_WAIT count before the timeout fires; the FSM leaves T_WAIT on
  // that cycle, so the 4-bit counter can never wrap.
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  logic irq_meip;

  trap_scheduler_irq_sync #(.N(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .resetn(resetn), .d(irq_sw_raw), .q(irq_msip)
  );
  trap_scheduler_irq_sync #(.N(SYNC_STAGES)) u_sync_tmr (
    .clk(clk), .resetn(resetn), .d(irq_tmr_raw), .q(irq_mtip)
  );
  trap_scheduler_irq_sync #(.N(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .resetn(resetn), .d(irq_ext_raw), .q(irq_meip)
  );

  // The external IRQ never goes through the CSR unit's mip, so it is merged
  // in here as MEIP.
  logic [31:0] pend;
  logic        gie;
  logic        any_irq;
  logic        irq_take;
  logic [4:0]  irq_code;

  assign pend     = (mip | {20'b0, irq_meip, 11'b0}) & mie;
  assign gie      = (privilege_mode == PRIVILEGE_MODE_U) | mstatus[MSTATUS_MIE];
  assign any_irq  = pend[IRQ_MEI] | pend[IRQ_MSI] | pend[IRQ_MTI];
  assign irq_take = gie & any_irq;

  always_comb begin
    irq_code = IRQ_MTI;
    if (pend[IRQ_MEI])      irq_code = IRQ_MEI;
    else if (pend[IRQ_MSI]) irq_code = IRQ_MSI;
  end

  logic unused_bits;
  assign unused_bits = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0],
                         mstatus[31:4], mstatus[2:0]};

  ts_state_e   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        latch_exc, latch_irq, fault_set;
  logic [31:0] cause_q, pc_q, badaddr_q;
  logic        fault_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= TS_RUN;
      cnt       <= '0;
      cause_q   <= '0;
      pc_q      <= '0;
      badaddr_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch_exc) begin
        cause_q   <= exc_cause;
        pc_q      <= exc_pc;
        badaddr_q <= exc_badaddr;
      end else if (latch_irq) begin
        cause_q   <= irq_cause(irq_code);
        pc_q      <= next_pc;
        badaddr_q <= '0;
      end
      if (fault_set) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    latch_exc = 1'b0;
    latch_irq = 1'b0;
    fault_set = 1'b0;
    case (state)
      TS_RUN: begin
        // An exception outranks both interrupts and a same-cycle WFI.
        if (exc_valid) begin
          latch_exc = 1'b1;
          state_n   = TS_REQ;
        end else if (boundary && irq_take) begin
          latch_irq = 1'b1;
          state_n   = TS_REQ;
        end else if (wfi) begin
          state_n = TS_SLEEP;
        end
      end
      TS_SLEEP: begin
        // Wake on any enabled pending IRQ even with interrupts globally
        // disabled; only trap if the global enable allows it.
        if (any_irq) begin
          if (irq_take) begin
            latch_irq = 1'b1;
            state_n   = TS_REQ;
          end else begin
            state_n = TS_RUN;
          end
        end
      end
      TS_REQ: begin
        state_n = TS_WAIT;
        cnt_n   = '0;
      end
      TS_WAIT: begin
        if (trap_bus.redirect_ack) begin
          state_n = TS_RUN;
        end else if (cnt == ACK_LAST) begin
          fault_set = 1'b1;
          state_n   = TS_RUN;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = TS_RUN;
    endcase
  end

  assign trap_bus.trap_event   = (state == TS_REQ);
  assign trap_bus.trap_cause   = cause_q;
  assign trap_bus.trap_pc      = pc_q;
  assign trap_bus.trap_badaddr = badaddr_q;

  assign hold      = (state != TS_RUN);
  assign sleeping  = (state == TS_SLEEP);
  assign ack_fault = fault_q;
  assign state_dbg = state;

endmodule
